// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and shared constants for the PLL reset sequencer.
//   S_PLLRST  PLL held in reset for a fixed number of cycles
//   S_WAIT    waiting for lock, bounded by a timeout
//   S_STABLE  lock seen, must persist before the core is released
//   S_RUN     core running
//   S_FAIL    retries exhausted, parked until restart or rst_n
package pll_seq_pkg;

  localparam logic [2:0] S_PLLRST = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam logic [7:0] LOSS_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == LOSS_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, flops clear to 0
//   d     in  asynchronous input
//   q     out synchronized output, two clk edges of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset/lock sequencing with timeout, retries and core reset release.
//   refclk        in  reference clock, sole clock of the block
//   rst_n         in  asynchronous active-low reset
//   restart       in  synchronous request to rerun the whole sequence
//   pll_locked    in  PLL lock, asynchronous to refclk
//   pll_rst       out active-high PLL reset
//   core_rst_n    out active-low core reset
//   ready         out high while in RUN
//   fail          out high while in FAIL
//   retry_cnt     out retries used in the current sequence
//   lock_loss_cnt out saturating count of lock losses seen in RUN
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17,
  parameter int RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_rst_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  logic [2:0]         state, state_n;
  logic [CNT_W-1:0]   timer, timer_n;
  logic [RETRY_W-1:0] retry_n;
  logic [7:0]         loss_n;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    loss_n  = lock_loss_cnt;
    if (restart) begin
      state_n = S_PLLRST;
      retry_n = '0;
    end else begin
      case (state)
        S_PLLRST: state_n = (timer == RST_LAST) ? S_WAIT : S_PLLRST;
        S_WAIT:
          if (locked_s)
            state_n = S_STABLE;
          else if (timer == TO_LAST) begin
            state_n = (retry_cnt == RETRY_MAX) ? S_FAIL : S_PLLRST;
            retry_n = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RETRY_W'(1);
          end
        // A lock glitch during STABLE restarts the wait without spending a retry.
        S_STABLE: state_n = !locked_s ? S_WAIT : (timer == STABLE_LAST) ? S_RUN : S_STABLE;
        S_RUN:
          if (!locked_s) begin
            state_n = S_PLLRST;
            retry_n = '0;
            loss_n  = sat_inc(lock_loss_cnt);
          end
        S_FAIL:   state_n = S_FAIL;
        default:  state_n = S_PLLRST;
      endcase
    end
  end

  // Timer runs only in the timed states and clears on any state change or restart,
  // so it never exceeds the largest terminal count and cannot wrap.
  assign timer_n = (restart || state_n != state) ? '0 :
                   (state == S_PLLRST || state == S_WAIT || state == S_STABLE) ? timer + CNT_W'(1) :
                   timer;

  // Outputs are decoded from the next state so they change on the entering edge.
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_PLLRST;
      timer         <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      core_rst_n    <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      pll_rst       <= (state_n == S_PLLRST) || (state_n == S_FAIL);
      core_rst_n    <= (state_n == S_RUN);
      ready         <= (state_n == S_RUN);
      fail          <= (state_n == S_FAIL);
    end

endmodule
